// File: rtl/_arb8.sv
// _mux8: 8:1 combinational data selector.
//   i_sel         3-bit select
//   i_in0..i_in7  n-bit data inputs
//   o_out         selected data
module _mux8 #(
  parameter int unsigned n = 16
) (
  input  logic [2:0]   i_sel,
  input  logic [n-1:0] i_in0,
  input  logic [n-1:0] i_in1,
  input  logic [n-1:0] i_in2,
  input  logic [n-1:0] i_in3,
  input  logic [n-1:0] i_in4,
  input  logic [n-1:0] i_in5,
  input  logic [n-1:0] i_in6,
  input  logic [n-1:0] i_in7,
  output logic [n-1:0] o_out
);

  always_comb begin
    o_out = i_in0;
    case (i_sel)
      3'd0:    o_out = i_in0;
      3'd1:    o_out = i_in1;
      3'd2:    o_out = i_in2;
      3'd3:    o_out = i_in3;
      3'd4:    o_out = i_in4;
      3'd5:    o_out = i_in5;
      3'd6:    o_out = i_in6;
      default: o_out = i_in7;
    endcase
  end

endmodule

// _arb8: round-robin arbiter sharing one valid/ready output among eight
// requesters, with locked multi-beat bursts.
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_req[7:0]        per-requester beat pending
//   i_lock[7:0]       current beat is not the last of a burst
//   i_in0..i_in7      requester data
//   i_out_ready       downstream accepts a beat this cycle
//   o_out_valid       beat presented on o_out_data
//   o_out_data        data of the selected requester
//   o_grant[7:0]      one-hot grant, zero when idle
//   o_sel[2:0]        current or last granted index
//   o_ack[7:0]        one-hot accept strobe (combinational with i_out_ready)
module _arb8 #(
  parameter int unsigned n = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_req,
  input  logic [7:0]   i_lock,
  input  logic [n-1:0] i_in0,
  input  logic [n-1:0] i_in1,
  input  logic [n-1:0] i_in2,
  input  logic [n-1:0] i_in3,
  input  logic [n-1:0] i_in4,
  input  logic [n-1:0] i_in5,
  input  logic [n-1:0] i_in6,
  input  logic [n-1:0] i_in7,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [n-1:0] o_out_data,
  output logic [7:0]   o_grant,
  output logic [2:0]   o_sel,
  output logic [7:0]   o_ack
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [2:0] w_win;
  logic [7:0] w_onehot;
  logic       w_busy;
  logic       w_accept;

  // Winner: first asserted request starting at r_ptr. Scanning from the
  // farthest offset down lets the nearest one overwrite the result.
  always_comb begin
    w_win = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (i_req[3'(r_ptr + 3'(k))]) w_win = 3'(r_ptr + 3'(k));
    end
  end

  assign w_busy      = (r_state == ST_BUSY);
  assign w_onehot    = 8'b1 << r_sel;
  assign o_sel       = r_sel;
  assign o_grant     = w_busy ? w_onehot : 8'h00;
  assign o_out_valid = w_busy & i_req[r_sel];
  assign w_accept    = o_out_valid & i_out_ready;
  assign o_ack       = w_accept ? w_onehot : 8'h00;

  _mux8 #(.n(n)) u_mux (
    .i_sel (r_sel),
    .i_in0 (i_in0),
    .i_in1 (i_in1),
    .i_in2 (i_in2),
    .i_in3 (i_in3),
    .i_in4 (i_in4),
    .i_in5 (i_in5),
    .i_in6 (i_in6),
    .i_in7 (i_in7),
    .o_out (o_out_data)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (i_req != 8'h00) begin
          w_sel_nxt   = w_win;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!i_req[r_sel]) begin
          // Withdrawal: requester keeps its priority.
          w_state_nxt = ST_IDLE;
        end else if (i_out_ready && !i_lock[r_sel]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = 3'(r_sel + 3'd1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/_arb8.md
# _arb8

Round-robin arbiter that shares one downstream resource between eight requesters. It drives an internal `_mux8` select so the granted requester's data is forwarded on a single `n`-bit output with a valid/ready handshake. Locked multi-beat bursts are supported. It sits in front of any shared single-port consumer (memory port, bus, writeback path) in the datapath.

## Interface
- `n`, default `BIT_WIDTH`: width of each data input and of `out_data`.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  `req[i]` high: requester i has a beat pending.
- `lock`  input  8  `lock[i]` high with `req[i]`: the current beat is not the last of a burst; keep the grant.
- `in0`..`in7`  input  n each  requester data.
- `out_ready`  input  1  downstream accepts a beat this cycle.
- `out_valid`  output  1  a beat is presented on `out_data`.
- `out_data`  output  n  data of the selected requester, via `_mux8`.
- `grant`  output  8  one-hot grant; all zero when IDLE.
- `sel`  output  3  index of the current or last grant; drives the `_mux8` select.
- `ack`  output  8  one-hot, combinational: `ack[sel] = out_valid & out_ready`.

## Operation
- State machine has two states, IDLE and BUSY. Registers are `state`, `sel[2:0]` and the priority pointer `ptr[2:0]`.
- IDLE:
  - If `req` != 0, the winner is the first asserted `req` bit searching `ptr`, `ptr+1`, … modulo 8.
  - The winner is loaded into `sel` and the state goes to BUSY.
  - If `req` == 0, the block stays in IDLE and `sel` holds its value.
- BUSY:
  - `grant` = one-hot(`sel`).
  - `out_valid` = `req[sel]`.
  - `out_data` = `_mux8(sel, in0..in7)`, combinational, so it tracks input changes.
- Accept cycle: `out_valid & out_ready` in BUSY.
  - `ack[sel]` = 1.
  - If `lock[sel]` = 1, the block stays in BUSY with the same `sel`. There is no bubble between beats, and `ptr` is unchanged.
  - If `lock[sel]` = 0, the burst ends: next state is IDLE and `ptr` <= `sel`+1. The 3-bit value wraps, so 7 goes to 0.
- Withdrawal: if `req[sel]` = 0 in BUSY, there is no ack. Next state is IDLE and `ptr` is unchanged. This is an abort and the requester keeps its priority.
- Stall: `out_valid` = 1 and `out_ready` = 0 holds `state` and `sel`, with no ack.
- Requester rules:
  - Hold `req` until acked.
  - Drop `req` or present the next beat on the cycle after an ack.
  - `lock` is sampled only in the accept cycle.
- No combinational path from `out_ready` to `grant` or `sel`. `ack` is the only output that depends combinationally on `out_ready`.

## Timing
- Reset, effective at the first edge with `reset` = 1:
  - `state` = IDLE, `sel` = 0, `ptr` = 0.
  - `grant` = 0, `out_valid` = 0, `ack` = 0.
  - `out_data` = `in0`.
  - `reset` overrides everything, including mid-burst and mid-stall, and discards any held grant.
- Grant latency:
  - `req` sampled high in IDLE at edge k gives `grant`, `out_valid` and `out_data` at cycle k+1.
  - The minimum beat latency is 1 cycle when `out_ready` = 1.
- Unlocked back-to-back transfers leave one IDLE cycle between grants, so peak throughput is 1 beat per 2 cycles. Locked bursts sustain 1 beat per cycle.
- An unlocked accept and a new `req` in the same cycle: the new `req` is arbitrated in the following IDLE cycle using the updated `ptr`.
- Fairness: with all `req` held, each requester is granted once per 8 grants.

## Test plan
- Reset:
  - Stimulus: `reset` = 1 for 2 cycles with `req` = 8'hFF.
  - Required: `grant` = 0, `out_valid` = 0 and `ack` = 0 throughout.
  - Required: 1 cycle after release, `grant` = 8'h01 and `sel` = 0.
- Single requester:
  - Stimulus: `req` = 8'h20, `in5` = 16'hBEEF, `out_ready` = 1.
  - Required: next cycle `grant` = 8'h20, `sel` = 5, `out_data` = 16'hBEEF, `ack` = 8'h20.
  - Required: the cycle after that is IDLE. If `req` is held, the next grant follows one cycle later.
- Round-robin:
  - Stimulus: `req` = 8'hFF held, `out_ready` = 1, unlocked.
  - Required: grants 0,1,…,7,0 in order, each followed by one IDLE cycle, with `ptr` wrapping 7 to 0.
- Backpressure:
  - Stimulus: grant to 3, then `out_ready` = 0 for 4 cycles while `in3` changes each cycle.
  - Required: `grant` stays at 8'h08, `out_data` follows `in3`, `ack` = 0.
  - Required: when `out_ready` = 1, `ack` = 8'h08 in that cycle.
- Locked burst:
  - Stimulus: `req` = 8'h0C, `ptr` = 0, requester 2 with `lock` = 1,1,0 over 3 beats, `out_ready` = 1.
  - Required: 3 consecutive acks to requester 2 with no bubble.
  - Required: then IDLE, then `grant` = 8'h08.
- Abort and reset mid-operation:
  - Stimulus: drop `req[4]` while it is granted.
  - Required: no ack, IDLE next cycle, `ptr` unchanged, and 4 is re-granted when it reasserts.
  - Stimulus: assert `reset` during a locked burst.
  - Required: next cycle all outputs are 0 and `ptr` = 0.
